pmod_rate_monitor: RTL and testbench

//  Multi-channel frequency/rate meter for DSO-free bring-up: counts rising edges of N_CH slow or

---
 rtl/pmod_rate_monitor_pkg.sv | 30 +++
 rtl/pmod_rate_monitor_channel.sv | 73 +++++++
 rtl/pmod_rate_monitor.sv | 129 ++++++++++++
 tb/tb_pmod_rate_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pmod_rate_monitor_pkg.sv
// Shared types and width helpers for the PMOD rate monitor.
// Holds the FSM state encoding and the gate-counter width derivation.
package pmod_rate_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_t;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_CNT_W       = 28;
    localparam int DEF_GATE_CYCLES = 27_000_000;
    localparam int DEF_SYNC_STAGES = 2;

    // Smallest width (at least 1) whose range covers 0..value-1.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int gate_width(input int gate_cycles);
        return clog2_min1(gate_cycles);
    endfunction

endpackage

// File: rtl/pmod_rate_monitor_channel.sv
// One monitored channel: synchroniser, rising-edge detect and saturating edge counter.
// O_count/O_ovf present the value including this cycle's edge, for publication on the last cycle.
module edge_rate_channel
    import pmod_rate_monitor_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_sig,
    input  logic             I_clear,
    input  logic             I_count_en,
    input  logic             I_last,
    output logic [CNT_W-1:0] O_count,
    output logic             O_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   ovf_reg;
    logic                   ovf_next;
    logic                   edge_det;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge I_clk) begin
                if (I_rst) sync_reg[gi] <= 1'b0;
                else       sync_reg[gi] <= I_sig;
            end
        end else begin : g_rest
            always_ff @(posedge I_clk) begin
                if (I_rst) sync_reg[gi] <= 1'b0;
                else       sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    // prev follows the synchroniser in every state, so a level already high when arming is not an edge.
    always_ff @(posedge I_clk) begin
        if (I_rst) prev_reg <= 1'b0;
        else       prev_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign edge_det = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (I_count_en && edge_det) begin
            if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
            else                    cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst || I_clear || I_last) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

    assign O_count = cnt_next;
    assign O_ovf   = ovf_next;

endmodule

// File: rtl/pmod_rate_monitor.sv
// Multi-channel edge-rate meter: counts rising edges per channel over a fixed gate window,
// publishes counts, range alarms, overflow flags and a per-window heartbeat toggle.
module pmod_rate_monitor
    import pmod_rate_monitor_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_enable,
    input  logic [N_CH-1:0]       I_sig,
    input  logic [CNT_W-1:0]      I_lo_thr,
    input  logic [CNT_W-1:0]      I_hi_thr,
    output logic [N_CH*CNT_W-1:0] O_count,
    output logic                  O_valid,
    output logic [N_CH-1:0]       O_alarm,
    output logic [N_CH-1:0]       O_overflow,
    output logic                  O_heartbeat,
    output logic                  O_busy
);

    localparam int GATE_W = gate_width(GATE_CYCLES);
    localparam int ARM_W  = clog2_min1(SYNC_STAGES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES);

    mon_state_t state_reg, state_next;
    logic [ARM_W-1:0]  arm_cnt_reg;
    logic [GATE_W-1:0] gate_cnt_reg;
    logic [CNT_W-1:0]  lo_reg, hi_reg;
    logic [CNT_W-1:0]  lo_cmp, hi_cmp;
    logic              measuring, first_cycle, last_cycle;

    logic [CNT_W-1:0]      ch_count [N_CH];
    logic [N_CH-1:0]       ch_ovf;
    logic [N_CH-1:0]       alarm_next;
    logic [N_CH*CNT_W-1:0] count_packed;

    logic [N_CH*CNT_W-1:0] count_reg;
    logic [N_CH-1:0]       alarm_reg, ovf_reg;
    logic                  valid_reg, heartbeat_reg, busy_reg;

    assign measuring   = (state_reg == ST_MEASURE);
    assign first_cycle = measuring && (gate_cnt_reg == '0);
    assign last_cycle  = measuring && (gate_cnt_reg == GATE_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (I_enable) state_next = ST_ARM;
            ST_ARM:     if (!I_enable) state_next = ST_IDLE;
                        else if (arm_cnt_reg == ARM_LAST) state_next = ST_MEASURE;
            ST_MEASURE: if (!I_enable) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_reg    <= ST_IDLE;
            arm_cnt_reg  <= '0;
            gate_cnt_reg <= '0;
            lo_reg       <= '0;
            hi_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            arm_cnt_reg <= (state_reg == ST_ARM) ? arm_cnt_reg + ARM_W'(1) : '0;
            if (measuring && !last_cycle) gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
            else                          gate_cnt_reg <= '0;
            if (first_cycle) begin
                lo_reg <= I_lo_thr;
                hi_reg <= I_hi_thr;
            end
        end
    end

    // On the first window cycle the registers are still loading, so compare against the live inputs.
    assign lo_cmp = first_cycle ? I_lo_thr : lo_reg;
    assign hi_cmp = first_cycle ? I_hi_thr : hi_reg;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        edge_rate_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .I_clk      (I_clk),
            .I_rst      (I_rst),
            .I_sig      (I_sig[gi]),
            .I_clear    (!measuring),
            .I_count_en (measuring),
            .I_last     (last_cycle),
            .O_count    (ch_count[gi]),
            .O_ovf      (ch_ovf[gi])
        );
        assign count_packed[gi*CNT_W +: CNT_W] = ch_count[gi];
        assign alarm_next[gi] = (ch_count[gi] < lo_cmp) || (ch_count[gi] > hi_cmp);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            count_reg     <= '0;
            alarm_reg     <= '0;
            ovf_reg       <= '0;
            valid_reg     <= 1'b0;
            heartbeat_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            valid_reg <= last_cycle;
            busy_reg  <= (state_next != ST_IDLE);
            if (last_cycle) begin
                count_reg     <= count_packed;
                alarm_reg     <= alarm_next;
                ovf_reg       <= ch_ovf;
                heartbeat_reg <= ~heartbeat_reg;
            end
        end
    end

    assign O_count     = count_reg;
    assign O_valid     = valid_reg;
    assign O_alarm     = alarm_reg;
    assign O_overflow  = ovf_reg;
    assign O_heartbeat = heartbeat_reg;
    assign O_busy      = busy_reg;

endmodule

// File: tb/tb_pmod_rate_monitor.sv
// Directed bench for pmod_rate_monitor: an 8-bit instance for rates/alarms/control
// and a 5-bit instance sharing the same stimulus for saturation.
module tb_pmod_rate_monitor;

    localparam int N_CH = 4;
    localparam int GATE = 100;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  sig = 4'b0;
    logic [7:0]  lo_thr = 8'd20;
    logic [7:0]  hi_thr = 8'd30;
    logic [4:0]  lo5 = 5'd0;
    logic [4:0]  hi5 = 5'd31;

    logic [31:0] count;
    logic        valid, hb, busy;
    logic [3:0]  alarm, ovf;
    logic [19:0] count5;
    logic        valid5, hb5, busy5;
    logic [3:0]  alarm5, ovf5;

    int   checks = 0;
    int   failures = 0;
    bit   lvl1 = 1'b0;
    int   mode2 = 2;
    int unsigned phase = 0;
    logic hb_exp = 1'b0;

    localparam logic [31:0] EXP  = {8'd10, 8'd30, 8'd0, 8'd25};
    localparam logic [19:0] EXP5 = {5'd10, 5'd30, 5'd0, 5'd25};

    pmod_rate_monitor #(.N_CH(N_CH), .CNT_W(8), .GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)) dut (
        .I_clk(clk), .I_rst(rst), .I_enable(enable), .I_sig(sig),
        .I_lo_thr(lo_thr), .I_hi_thr(hi_thr),
        .O_count(count), .O_valid(valid), .O_alarm(alarm), .O_overflow(ovf),
        .O_heartbeat(hb), .O_busy(busy)
    );

    pmod_rate_monitor #(.N_CH(N_CH), .CNT_W(5), .GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)) dut5 (
        .I_clk(clk), .I_rst(rst), .I_enable(enable), .I_sig(sig),
        .I_lo_thr(lo5), .I_hi_thr(hi5),
        .O_count(count5), .O_valid(valid5), .O_alarm(alarm5), .O_overflow(ovf5),
        .O_heartbeat(hb5), .O_busy(busy5)
    );

    always #5 clk = ~clk;

    // ch0: period 4, ch1: static level, ch2: selectable, ch3: period 10. All periods divide the window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            phase = phase + 1;
            sig[0] = ((phase % 4) < 2);
            sig[1] = lvl1;
            case (mode2)
                1:       sig[2] = phase[0];
                2:       sig[2] = ((phase % 10) == 0) || ((phase % 10) == 3) || ((phase % 10) == 6);
                default: sig[2] = 1'b0;
            endcase
            sig[3] = ((phase % 10) < 5);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < 300);
        checks++;
        if (!valid) begin
            failures++;
            $display("FAIL wait_valid: no O_valid within %0d cycles", n);
        end else begin
            hb_exp = ~hb_exp;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        checks++; if (count !== 32'd0) begin failures++; $display("FAIL reset_count: got %h want 0", count); end
        checks++; if ({valid, alarm, ovf, hb, busy} !== 11'd0) begin failures++; $display("FAIL reset_flags: got %b want 0", {valid, alarm, ovf, hb, busy}); end
        checks++; if ({count5, valid5, busy5} !== 22'd0) begin failures++; $display("FAIL reset_dut5: got %h want 0", {count5, valid5, busy5}); end
        $display("test_reset done");
        rst = 1'b0;
        step();
    endtask

    task automatic test_level_before_enable;
        lvl1 = 1'b1;
        repeat (10) step();
        enable = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_arm: got %b want 1", busy); end
        $display("test_level_before_enable: enable raised with ch1 high");
    endtask

    task automatic test_rates;
        int n;
        wait_valid(n);
        checks++; if (n !== 103) begin failures++; $display("FAIL first_latency: got %0d want 103", n); end
        checks++; if (count !== EXP) begin failures++; $display("FAIL win1_count: got %h want %h", count, EXP); end
        checks++; if (alarm !== 4'b1010) begin failures++; $display("FAIL win1_alarm: got %b want 1010", alarm); end
        checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL win1_ovf: got %b want 0000", ovf); end
        checks++; if (hb !== hb_exp) begin failures++; $display("FAIL win1_hb: got %b want %b", hb, hb_exp); end
        checks++; if (count5 !== EXP5 || alarm5 !== 4'b0000) begin failures++; $display("FAIL win1_dut5: got %h/%b want %h/0000", count5, alarm5, EXP5); end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL valid_pulse: got %b want 0", valid); end
        wait_valid(n);
        checks++; if (n !== 99) begin failures++; $display("FAIL window_period: got %0d want 99", n); end
        checks++; if (count !== EXP || hb !== hb_exp) begin failures++; $display("FAIL win2: got %h hb %b want %h hb %b", count, hb, EXP, hb_exp); end
        $display("test_rates: count=%h alarm=%b hb=%b", count, alarm, hb);
    endtask

    task automatic test_threshold_hold;
        int n;
        repeat (50) step();
        lo_thr = 8'd40;
        hi_thr = 8'd10;
        wait_valid(n);
        checks++; if (alarm !== 4'b1010) begin failures++; $display("FAIL thr_held: got %b want 1010", alarm); end
        wait_valid(n);
        checks++; if (alarm !== 4'b1111) begin failures++; $display("FAIL lo_gt_hi: got %b want 1111", alarm); end
        lo_thr = 8'd20;
        hi_thr = 8'd30;
        wait_valid(n);
        $display("test_threshold_hold: lo>hi alarm checked");
    endtask

    task automatic test_overflow;
        int n;
        mode2 = 1;
        wait_valid(n);
        wait_valid(n);
        checks++; if (count[23:16] !== 8'd50 || ovf !== 4'b0000) begin failures++; $display("FAIL ch2_50: got %0d ovf %b want 50 ovf 0000", count[23:16], ovf); end
        checks++; if (alarm !== 4'b1110) begin failures++; $display("FAIL ch2_50_alarm: got %b want 1110", alarm); end
        checks++; if (count5[14:10] !== 5'd31 || ovf5 !== 4'b0100) begin failures++; $display("FAIL sat: got %0d ovf %b want 31 ovf 0100", count5[14:10], ovf5); end
        checks++; if (alarm5[2] !== 1'b0) begin failures++; $display("FAIL sat_alarm_eq_hi: got %b want 0", alarm5[2]); end
        mode2 = 0;
        wait_valid(n);
        wait_valid(n);
        checks++; if (count5[14:10] !== 5'd0 || ovf5 !== 4'b0000) begin failures++; $display("FAIL quiet: got %0d ovf %b want 0 ovf 0000", count5[14:10], ovf5); end
        checks++; if (count[23:16] !== 8'd0) begin failures++; $display("FAIL quiet8: got %0d want 0", count[23:16]); end
        mode2 = 2;
        wait_valid(n);
        wait_valid(n);
        checks++; if (count !== EXP) begin failures++; $display("FAIL restore: got %h want %h", count, EXP); end
        $display("test_overflow: saturation and quiet window checked");
    endtask

    task automatic test_abort;
        int n;
        bit seen;
        repeat (50) step();
        enable = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL abort_busy: got busy %b valid %b want 0 0", busy, valid); end
        seen = 1'b0;
        repeat (150) begin
            step();
            if (valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_valid: got valid pulse want none"); end
        checks++; if (count !== EXP || alarm !== 4'b1010 || hb !== hb_exp) begin failures++; $display("FAIL abort_hold: got %h %b %b want %h 1010 %b", count, alarm, hb, EXP, hb_exp); end
        enable = 1'b1;
        step();
        wait_valid(n);
        checks++; if (n !== 103) begin failures++; $display("FAIL reenable_latency: got %0d want 103", n); end
        checks++; if (count !== EXP) begin failures++; $display("FAIL reenable_count: got %h want %h", count, EXP); end
        $display("test_abort: abort and re-enable checked, latency %0d", n);
    endtask

    task automatic test_reset_mid;
        int n;
        repeat (50) step();
        rst = 1'b1;
        step();
        checks++; if ({count, alarm, ovf, hb, busy, valid} !== 43'd0) begin failures++; $display("FAIL midreset: got %h want 0", {count, alarm, ovf, hb, busy, valid}); end
        rst = 1'b0;
        hb_exp = 1'b0;
        step();
        wait_valid(n);
        checks++; if (n !== 103) begin failures++; $display("FAIL postreset_latency: got %0d want 103", n); end
        checks++; if (count !== EXP || hb !== 1'b1) begin failures++; $display("FAIL postreset: got %h hb %b want %h hb 1", count, hb, EXP); end
        $display("test_reset_mid: recovery checked");
    endtask

    initial begin
        test_reset();
        test_level_before_enable();
        test_rates();
        test_threshold_hold();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
